// File: rtl/sram_8t_rw_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_8t_rw_ctrl_if
// Request/response bus between a requester and the 8T SRAM row controller.
//   req_valid / req_ready : request handshake, accepted when both are 1
//   req_we                : 1 = write, 0 = read
//   req_addr              : row address (ADDR_W bits)
//   req_wdata             : write data (DATA_W bits)
//   rsp_valid             : one-cycle completion pulse
//   rsp_rdata             : read data, held until the next read completes
//   rsp_err               : readback mismatch flag, valid with rsp_valid
// Modports: master (requester side), slave (controller side).
// -----------------------------------------------------------------------------
interface sram_8t_rw_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_8t_rw_ctrl.sv
// -----------------------------------------------------------------------------
// sram_8t_rw_ctrl
// Read/write sequencer for an 8T SRAM array with separate write wordlines
// (wwl) and read wordlines (rwl). A write sets up the bitlines for one cycle,
// pulses the write wordline for WPULSE_CYC cycles and holds the bitlines one
// more cycle. A read enables the read wordline for two cycles and captures the
// column outputs on the edge leaving RD_CAP.
//
// Ports:
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : request/response bus (sram_8t_rw_ctrl_if.slave)
//   bl         : registered bitline drive to the array columns
//   wwl, rwl   : registered one-hot write / read wordlines (2**ADDR_W rows)
//   q_col      : per-column OR of the bitcell read outputs
//
// Optional feature: define SRAM_CTRL_READ_VERIFY_EN to read every written row
// back (RB_EN, RB_CAP) and flag a mismatch on rsp_err. Without it rsp_err is 0.
// -----------------------------------------------------------------------------
module sram_8t_rw_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int WPULSE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram_8t_rw_ctrl_if.slave       bus,
    output logic [DATA_W-1:0]      bl,
    output logic [(2**ADDR_W)-1:0] wwl,
    output logic [(2**ADDR_W)-1:0] rwl,
    input  logic [DATA_W-1:0]      q_col
);
    localparam int DEPTH  = 2 ** ADDR_W;
    // A zero or negative pulse width degenerates to a single-cycle pulse.
    localparam int WP_EFF = (WPULSE_CYC < 1) ? 1 : WPULSE_CYC;
    localparam int CNT_W  = (WP_EFF > 1) ? $clog2(WP_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WP_EFF - 1);

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        WPULSE,
        HOLD,
`ifdef SRAM_CTRL_READ_VERIFY_EN
        RB_EN,
        RB_CAP,
`endif
        RD_EN,
        RD_CAP,
        DONE
    } state_e;

    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                we_q,        we_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [DATA_W-1:0]   bl_q,        bl_d;
    logic [DEPTH-1:0]    wwl_q,       wwl_d;
    logic [DEPTH-1:0]    rwl_q,       rwl_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [DEPTH-1:0]    row_sel;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path through
        // this block leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // req_ready is 1 only here, so req_valid alone means accept.
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = bus.req_we ? SETUP : RD_EN;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = WPULSE;
            end
            WPULSE: begin
                if (cnt_q == CNT_LAST) state_d = HOLD;
                else                   cnt_d   = cnt_q + 1'b1;
            end
`ifdef SRAM_CTRL_READ_VERIFY_EN
            HOLD:   state_d = RB_EN;
            RB_EN:  state_d = RB_CAP;
            RB_CAP: begin
                // Flag is produced only on the edge into DONE, so it is
                // high for the single rsp_valid cycle and 0 elsewhere.
                rsp_err_d = (q_col != wdata_q);
                state_d   = DONE;
            end
`else
            HOLD:   state_d = DONE;
`endif
            RD_EN:  state_d = RD_CAP;
            RD_CAP: begin
                rsp_rdata_d = q_col;
                state_d     = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state, so each wordline and
        // bitline flop changes on the same edge the FSM enters its state.
        row_sel     = DEPTH'(1) << addr_d;
        bl_d        = (state_d == SETUP || state_d == WPULSE || state_d == HOLD)
                      ? wdata_d : '0;
        wwl_d       = (state_d == WPULSE) ? row_sel : '0;
        rwl_d       = '0;
        if (state_d == RD_EN || state_d == RD_CAP) rwl_d = row_sel;
`ifdef SRAM_CTRL_READ_VERIFY_EN
        if (state_d == RB_EN || state_d == RB_CAP) rwl_d = row_sel;
`endif
        rsp_valid_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bl_q        <= '0;
            wwl_q       <= '0;
            rwl_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            bl_q        <= bl_d;
            wwl_q       <= wwl_d;
            rwl_q       <= rwl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bl            = bl_q;
    assign wwl           = wwl_q;
    assign rwl           = rwl_q;

    // we_q is kept for debug visibility of the in-flight request type.
    logic unused_we;
    assign unused_we = we_q;
endmodule
